dmem_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters.
- Requester P is the pipeline EX/M stage. Requester L is the program loader/debug port.
- Sequences each access over a fixed memory latency, returns read data and a one-cycle valid to the winner, and stalls the pipeline while its access is pending.
- Sits between the EX/M stage and data_memory.

---
 rtl/dmem_arbiter_pkg.sv | 18 +
 rtl/arb_starve_ctr.sv | 37 +++
 rtl/dmem_arbiter.sv | 114 +++++++++++
 tb/tb_dmem_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, owner codes and counter width.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef logic owner_t;

  localparam owner_t OWN_P = 1'b0;
  localparam owner_t OWN_L = 1'b1;

  // Wide enough for MEM_LAT-1 and STARVE_MAX, both capped at 15.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of cycles the loader has been kept waiting; at_max forces its next grant.
module arb_starve_ctr
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic l_req,
  input  logic l_grant,
  output logic at_max
);

  localparam logic [CNT_W-1:0] MaxVal = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!l_req || l_grant) begin
      cnt_d = '0;
    end else if (cnt_q != MaxVal) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == MaxVal);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the pipeline (P) and the loader (L), one access at a time
// over a fixed memory latency, with a starvation guard for L.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p_req,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic [DW-1:0] p_rdata,
  output logic          p_valid,
  output logic          p_stall,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic [DW-1:0] l_rdata,
  output logic          l_valid,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LatInit = CNT_W'(MEM_LAT - 1);

  state_e           state_q;
  owner_t           owner_q;
  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic [DW-1:0]    p_rdata_q, l_rdata_q;
  logic [CNT_W-1:0] lat_q;

  logic any_req, pick_l, l_grant, at_max;

  assign any_req = p_req | l_req;
  // P has priority unless L has waited the full starvation window.
  assign pick_l  = l_req & (~p_req | at_max);
  assign l_grant = (state_q == ST_IDLE) & pick_l;

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .rst_n   (rst_n),
    .l_req   (l_req),
    .l_grant (l_grant),
    .at_max  (at_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_P;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      lat_q     <= '0;
      p_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            owner_q <= pick_l ? OWN_L : OWN_P;
            we_q    <= pick_l ? l_we : p_we;
            addr_q  <= pick_l ? l_addr : p_addr;
            wdata_q <= pick_l ? l_wdata : p_wdata;
            lat_q   <= LatInit;
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (lat_q == '0) begin
            if (!we_q) begin
              if (owner_q == OWN_L) begin
                l_rdata_q <= mem_rdata;
              end else begin
                p_rdata_q <= mem_rdata;
              end
            end
            state_q <= ST_DONE;
          end else begin
            lat_q <= lat_q - CNT_W'(1);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode from registered state so an asynchronous reset drops them at once.
  assign mem_read  = (state_q == ST_ACCESS) & ~we_q;
  assign mem_write = (state_q == ST_ACCESS) & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign p_valid = (state_q == ST_DONE) & (owner_q == OWN_P);
  assign l_valid = (state_q == ST_DONE) & (owner_q == OWN_L);
  assign p_rdata = p_rdata_q;
  assign l_rdata = l_rdata_q;
  assign p_stall = p_req & ~p_valid;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, corner sequences and a randomized run
// against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int unsigned LAT1 = 1;
  localparam int unsigned LAT3 = 3;
  localparam int unsigned SMAX = 4;

  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT with MEM_LAT = 1
  logic        p_req, p_we, p_valid, p_stall, l_req, l_we, l_valid, mem_read, mem_write;
  logic [31:0] p_addr, p_wdata, p_rdata, l_addr, l_wdata, l_rdata, mem_addr, mem_wdata, mem_rdata;
  // DUT with MEM_LAT = 3
  logic        p_req3, p_we3, p_valid3, p_stall3, l_req3, l_we3, l_valid3, mem_read3, mem_write3;
  logic [31:0] p_addr3, p_wdata3, p_rdata3, l_addr3, l_wdata3, l_rdata3;
  logic [31:0] mem_addr3, mem_wdata3, mem_rdata3;

  int n_checks = 0;
  int n_pass   = 0;

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT1), .STARVE_MAX(SMAX)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_valid(p_valid), .p_stall(p_stall),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_rdata(l_rdata), .l_valid(l_valid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT3), .STARVE_MAX(SMAX)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .p_req(p_req3), .p_we(p_we3), .p_addr(p_addr3), .p_wdata(p_wdata3),
    .p_rdata(p_rdata3), .p_valid(p_valid3), .p_stall(p_stall3),
    .l_req(l_req3), .l_we(l_we3), .l_addr(l_addr3), .l_wdata(l_wdata3),
    .l_rdata(l_rdata3), .l_valid(l_valid3),
    .mem_read(mem_read3), .mem_write(mem_write3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  function automatic logic [31:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEAD_BEEF : (32'h1000_0000 | {24'h0, a});
  endfunction

  // Memory stand-ins: data is only presented on the cycle MEM_LAT after the strobe begins.
  logic [31:0] dev1 [256];
  bit          dv1  [256];
  int          age1 = 0;
  int          age3 = 0;

  always @(posedge clk) begin
    if (mem_write) begin
      dev1[mem_addr[7:0]] <= mem_wdata;
      dv1[mem_addr[7:0]]  <= 1'b1;
    end
    age1 <= mem_read ? age1 + 1 : 0;
    age3 <= mem_read3 ? age3 + 1 : 0;
  end

  always_comb begin
    mem_rdata = 32'hBAD0_BAD0;
    if (mem_read && age1 == int'(LAT1) - 1)
      mem_rdata = dv1[mem_addr[7:0]] ? dev1[mem_addr[7:0]] : init_val(mem_addr[7:0]);
  end

  always_comb begin
    mem_rdata3 = 32'hBAD0_BAD0;
    if (mem_read3 && age3 == int'(LAT3) - 1) mem_rdata3 = {16'hC0DE, mem_addr3[15:0]};
  end

  // Reference memory contents as seen by requesters.
  logic [31:0] ref_mem [256];
  bit          ref_vld [256];

  function automatic logic [31:0] ref_read(input logic [7:0] a);
    return ref_vld[a] ? ref_mem[a] : init_val(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("excl_valid1", 32'(p_valid & l_valid), 32'd0);
      check("excl_strobe1", 32'(mem_read & mem_write), 32'd0);
      check("excl_valid3", 32'(p_valid3 & l_valid3), 32'd0);
      check("excl_strobe3", 32'(mem_read3 & mem_write3), 32'd0);
    end
  end

  task automatic do_txn(input bit is_l, input bit we, input logic [31:0] addr, wdata,
                        output int lat, output int nrd, output int nwr,
                        output bit addr_ok, output bit stall_ok, output logic [31:0] rdata);
    @(posedge clk); #1;
    if (is_l) begin
      l_req = 1'b1; l_we = we; l_addr = addr; l_wdata = wdata;
    end else begin
      p_req = 1'b1; p_we = we; p_addr = addr; p_wdata = wdata;
    end
    lat = -1; nrd = 0; nwr = 0; addr_ok = 1'b1; stall_ok = 1'b1; rdata = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_read) nrd++;
      if (mem_write) nwr++;
      if ((mem_read || mem_write) && mem_addr != addr) addr_ok = 1'b0;
      if (mem_write && mem_wdata != wdata) addr_ok = 1'b0;
      if (!is_l && (p_stall == p_valid)) stall_ok = 1'b0;
      if (is_l ? l_valid : p_valid) begin
        lat = c;
        rdata = is_l ? l_rdata : p_rdata;
        break;
      end
    end
    @(posedge clk); #1;
    p_req = 1'b0; l_req = 1'b0;
  endtask

  // P read on the MEM_LAT=3 instance; p_addr is scrambled right after the grant cycle.
  task automatic txn3(input logic [31:0] addr, output int lat, output int nrd,
                      output bit addr_ok, output bit stall_ok, output logic [31:0] rdata);
    @(posedge clk); #1;
    p_req3 = 1'b1; p_we3 = 1'b0; p_addr3 = addr;
    lat = -1; nrd = 0; addr_ok = 1'b1; stall_ok = 1'b1; rdata = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_read3) begin
        nrd++;
        if (mem_addr3 != addr) addr_ok = 1'b0;
      end
      if (mem_write3) addr_ok = 1'b0;
      if (p_stall3 == p_valid3) stall_ok = 1'b0;
      if (p_valid3) begin
        lat = c;
        rdata = p_rdata3;
        break;
      end
      if (c == 0) begin
        @(posedge clk); #1;
        p_addr3 = ~addr;
      end
    end
    @(posedge clk); #1;
    p_req3 = 1'b0;
  endtask

  typedef struct {
    bit          is_l;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;  // requester's rdata at valid (unchanged for writes)
  } vec_t;

  vec_t        vecs [9];
  int          lat, nrd, nwr, pulses;
  bit          addr_ok, stall_ok;
  logic [31:0] rdata, last_p;
  int          owners[$];
  int          whens[$];
  int          exp_own [6];

  // Random-phase model state
  int          phase, starve;
  bit          own_l, m_we, gl, p_act, l_act, p_gr, l_gr, e_rd, e_wr, e_pv, e_lv;
  logic [31:0] m_addr, m_wdata, p_last, l_last;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h20, 32'h1234_5678, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h20, 32'h0,         32'h1234_5678};
    vecs[3] = '{1'b0, 1'b1, 32'h30, 32'hCAFE_F00D, 32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 1'b0, 32'h30, 32'h0,         32'hCAFE_F00D};
    vecs[5] = '{1'b1, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF};
    vecs[6] = '{1'b0, 1'b0, 32'h24, 32'h0,         32'h1000_0024};
    vecs[7] = '{1'b1, 1'b1, 32'h10, 32'hA5A5_A5A5, 32'hDEAD_BEEF};
    vecs[8] = '{1'b0, 1'b0, 32'h10, 32'h0,         32'hA5A5_A5A5};
    exp_own = '{0, 0, 1, 0, 1, 0};

    rst_n = 1'b0;
    p_req = 1'b1; p_we = 1'b0; p_addr = '0; p_wdata = '0;
    l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
    p_req3 = 1'b0; p_we3 = 1'b0; p_addr3 = '0; p_wdata3 = '0;
    l_req3 = 1'b0; l_we3 = 1'b0; l_addr3 = '0; l_wdata3 = '0;

    // Reset state
    @(negedge clk);
    check("reset_p_stall", 32'(p_stall), 32'd1);
    check("reset_p_valid", 32'(p_valid), 32'd0);
    check("reset_l_valid", 32'(l_valid), 32'd0);
    check("reset_mem_read", 32'(mem_read), 32'd0);
    check("reset_mem_write", 32'(mem_write), 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_p_rdata", p_rdata, 32'd0);
    check("reset_l_rdata", l_rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; p_req = 1'b0;

    // Single-requester transactions, MEM_LAT = 1
    for (int i = 0; i < 9; i++) begin
      do_txn(vecs[i].is_l, vecs[i].we, vecs[i].addr, vecs[i].wdata,
             lat, nrd, nwr, addr_ok, stall_ok, rdata);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT1 + 1));
      check($sformatf("vec%0d_read_cycles", i), 32'(nrd), vecs[i].we ? 32'd0 : 32'(LAT1));
      check($sformatf("vec%0d_write_cycles", i), 32'(nwr), vecs[i].we ? 32'(LAT1) : 32'd0);
      check($sformatf("vec%0d_mem_addr_data", i), 32'(addr_ok), 32'd1);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      if (!vecs[i].is_l) check($sformatf("vec%0d_p_stall", i), 32'(stall_ok), 32'd1);
      if (vecs[i].we) begin
        ref_mem[vecs[i].addr[7:0]] = vecs[i].wdata;
        ref_vld[vecs[i].addr[7:0]] = 1'b1;
      end
    end

    // Both requesting continuously: grants at cycles 0,3,6,.. go P,P,L,P,L,P
    @(posedge clk); #1;
    p_req = 1'b1; p_we = 1'b0; p_addr = 32'h4;
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h8;
    last_p = '0;
    for (int c = 0; c < 40 && owners.size() < 6; c++) begin
      @(negedge clk);
      if (p_valid) begin owners.push_back(0); whens.push_back(c); last_p = p_rdata; end
      if (l_valid) begin owners.push_back(1); whens.push_back(c); end
    end
    @(posedge clk); #1;
    p_req = 1'b0; l_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("starve_owner%0d", i), 32'(owners.size() > i ? owners[i] : -1),
            32'(exp_own[i]));
      check($sformatf("starve_when%0d", i), 32'(whens.size() > i ? whens[i] : -1),
            32'(2 + 3 * i));
    end
    check("starve_p_rdata", last_p, init_val(8'h04));
    check("starve_l_rdata", l_rdata, init_val(8'h08));

    // MEM_LAT = 3 read with p_addr changed after grant
    txn3(32'h40, lat, nrd, addr_ok, stall_ok, rdata);
    check("lat3_latency", 32'(lat), 32'(LAT3 + 1));
    check("lat3_read_cycles", 32'(nrd), 32'(LAT3));
    check("lat3_addr_latched", 32'(addr_ok), 32'd1);
    check("lat3_p_stall", 32'(stall_ok), 32'd1);
    check("lat3_rdata", rdata, 32'hC0DE_0040);

    // Reset in the middle of a MEM_LAT = 3 read
    @(posedge clk); #1;
    p_req3 = 1'b1; p_we3 = 1'b0; p_addr3 = 32'h44;
    @(negedge clk);
    @(negedge clk);
    check("midrst_strobe_before", 32'(mem_read3), 32'd1);
    #2;
    rst_n = 1'b0; p_req = 1'b1;
    #1;
    check("midrst_strobe_async", 32'(mem_read3), 32'd0);
    check("midrst_p_stall_eq_req", 32'(p_stall), 32'd1);
    check("midrst_p_rdata_cleared", p_rdata, 32'd0);
    check("midrst_mem_addr_cleared", mem_addr3, 32'd0);
    p_req3 = 1'b0; p_req = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (p_valid3) pulses++;
    end
    check("midrst_no_valid", 32'(pulses), 32'd0);
    txn3(32'h48, lat, nrd, addr_ok, stall_ok, rdata);
    check("postrst_latency", 32'(lat), 32'(LAT3 + 1));
    check("postrst_read_cycles", 32'(nrd), 32'(LAT3));
    check("postrst_rdata", rdata, 32'hC0DE_0048);

    // Randomized traffic on the MEM_LAT = 1 instance
    phase = -1; starve = 0;
    p_act = 1'b0; l_act = 1'b0; p_gr = 1'b0; l_gr = 1'b0;
    own_l = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    p_last = '0; l_last = '0;
    repeat (600) begin
      @(posedge clk); #1;
      if (!p_act) begin
        if ($urandom_range(0, 2) == 0) begin
          p_act = 1'b1; p_gr = 1'b0; p_req = 1'b1;
          p_we = 1'($urandom_range(0, 1));
          p_addr = 32'($urandom_range(0, 15)) << 2;
          p_wdata = $urandom;
        end else p_req = 1'b0;
      end else if (p_gr) begin
        p_we = 1'($urandom_range(0, 1)); p_addr = $urandom; p_wdata = $urandom;
      end
      if (!l_act) begin
        if ($urandom_range(0, 2) == 0) begin
          l_act = 1'b1; l_gr = 1'b0; l_req = 1'b1;
          l_we = 1'($urandom_range(0, 1));
          l_addr = 32'($urandom_range(0, 15)) << 2;
          l_wdata = $urandom;
        end else l_req = 1'b0;
      end else if (l_gr) begin
        l_we = 1'($urandom_range(0, 1)); l_addr = $urandom; l_wdata = $urandom;
      end

      @(negedge clk);
      e_rd = 1'b0; e_wr = 1'b0; e_pv = 1'b0; e_lv = 1'b0; gl = 1'b0;
      if (phase < 0) begin
        if (p_req || l_req) begin
          own_l   = l_req && (!p_req || starve == int'(SMAX));
          gl      = own_l;
          m_we    = own_l ? l_we : p_we;
          m_addr  = own_l ? l_addr : p_addr;
          m_wdata = own_l ? l_wdata : p_wdata;
          phase   = 0;
          if (own_l) l_gr = 1'b1; else p_gr = 1'b1;
        end
      end else if (phase <= int'(LAT1)) begin
        e_rd = !m_we; e_wr = m_we;
      end else begin
        if (own_l) e_lv = 1'b1; else e_pv = 1'b1;
        if (m_we) begin
          ref_mem[m_addr[7:0]] = m_wdata;
          ref_vld[m_addr[7:0]] = 1'b1;
        end else if (own_l) l_last = ref_read(m_addr[7:0]);
        else p_last = ref_read(m_addr[7:0]);
      end

      check("rnd_mem_read", 32'(mem_read), 32'(e_rd));
      check("rnd_mem_write", 32'(mem_write), 32'(e_wr));
      if (e_rd || e_wr) check("rnd_mem_addr", mem_addr, m_addr);
      if (e_wr) check("rnd_mem_wdata", mem_wdata, m_wdata);
      check("rnd_p_valid", 32'(p_valid), 32'(e_pv));
      check("rnd_l_valid", 32'(l_valid), 32'(e_lv));
      check("rnd_p_rdata", p_rdata, p_last);
      check("rnd_l_rdata", l_rdata, l_last);
      check("rnd_p_stall", 32'(p_stall), 32'(p_req && !e_pv));

      if (phase >= 0) phase = (phase == int'(LAT1) + 1) ? -1 : phase + 1;
      if (!l_req || gl) starve = 0;
      else if (starve < int'(SMAX)) starve++;
      if (e_pv) begin p_act = 1'b0; p_gr = 1'b0; end
      if (e_lv) begin l_act = 1'b0; l_gr = 1'b0; end
    end
    @(posedge clk); #1;
    p_req = 1'b0; l_req = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
